button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 10000, meaning the number of consecutive clk cycles a synchronized input must differ from its debounced value before it is accepted (10 ms at 1 MHz); legal range 2..65535.
REQ-002 SHALL have port clk, input, 1 bit: the single 1 MHz system clock; all state updates on its rising edge.
REQ-003 SHALL have port res, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port btn_start_stop, input, 1 bit: raw asynchronous start/stop button, active-high.
REQ-005 SHALL have port btn_lap, input, 1 bit: raw asynchronous lap button, active-high.
REQ-006 SHALL have port btn_clear, input, 1 bit: raw asynchronous clear button, active-high.
REQ-007 SHALL have port start_stop_pulse, output, 1 bit: one-cycle strobe per accepted start/stop press.
REQ-008 SHALL have port lap_pulse, output, 1 bit: one-cycle strobe per accepted lap press.
REQ-009 SHALL have port clear_pulse, output, 1 bit: one-cycle strobe per accepted clear press.
REQ-010 SHALL have port counter_enable, output, 1 bit: high while the stopwatch counts.
REQ-011 SHALL have port display_enable, output, 1 bit: high while the display tracks live time; low means the lap value is frozen.

Function
REQ-012 SHALL pass each raw button through its own two-flop synchronizer before any other logic uses it.
REQ-013 SHALL give each channel a debounced level register and a counter of ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-014 SHALL clear a channel's counter to 0 in any cycle where the synchronized value equals the debounced level.
REQ-015 SHALL increment a channel's counter in any cycle where the synchronized value differs from the debounced level and the counter is below DEBOUNCE_CYCLES-1.
REQ-016 SHALL, when a differing cycle finds the counter at DEBOUNCE_CYCLES-1, load the synchronized value into the debounced level and clear the counter.
REQ-017 SHALL ignore any input disturbance shorter than DEBOUNCE_CYCLES consecutive synchronized cycles: the level, pulse and enables stay unchanged.
REQ-018 SHALL drive each *_pulse output from a register, high for exactly one cycle, in the cycle after that channel's debounced level goes 0->1.
REQ-019 SHALL produce no pulse on a 1->0 debounced transition; a held button produces exactly one pulse.
REQ-020 SHALL give a latency of exactly DEBOUNCE_CYCLES+3 clk edges from the first edge that samples a clean raw 1 to the pulse being high: 2 synchronizer, DEBOUNCE_CYCLES counting, 1 pulse register.
REQ-021 SHALL toggle counter_enable in the cycle after start_stop_pulse is high.
REQ-022 SHALL toggle display_enable in the cycle after lap_pulse is high.
REQ-023 SHALL, in the cycle after clear_pulse is high, force counter_enable=0 and display_enable=1.
REQ-024 SHALL give clear priority over start_stop and lap pulses that are high in the same cycle.
REQ-025 SHALL apply simultaneous start_stop and lap pulses (without clear) together, both toggles in the same cycle.
REQ-026 SHALL keep the three channels fully independent; no channel's debounce timing affects another.

Reset
REQ-027 SHALL, while res is high at a clk edge, clear all synchronizer flops, debounced levels, counters and pulse outputs to 0, set counter_enable=0, and set display_enable=1.
REQ-028 SHALL discard any in-progress debounce count when res is asserted mid-count.
REQ-029 SHALL treat a button held through reset release as a new press: it yields one pulse DEBOUNCE_CYCLES+3 edges after release.
REQ-030 SHALL assert no output glitch during the reset cycle or the cycle after it.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 SHALL cover clean press: btn_start_stop raised and held 20 cycles after reset -> start_stop_pulse high for exactly 1 cycle, 7 edges after first sample; counter_enable goes 0->1 on the next cycle; no pulse on release.
REQ-032 SHALL cover bounce: btn_lap toggled 1,0,1,0 on alternate cycles, then held 1 -> no pulse during the bounce; one lap_pulse 7 edges after the final rise; display_enable goes 1->0; a second press returns it to 1.
REQ-033 SHALL cover glitch rejection: btn_clear high for 3 cycles, then low -> clear_pulse stays 0 and both enables are unchanged.
REQ-034 SHALL cover simultaneous events: with counter_enable=1 and display_enable=0, all three buttons pressed on the same edge -> all pulses coincide; the next cycle shows counter_enable=0 and display_enable=1.
REQ-035 SHALL cover reset mid-count: btn_start_stop held, res pulsed 1 cycle after 2 counting cycles -> counter_enable stays 0 and the pulse appears 7 edges after res deasserts.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces three stopwatch buttons into
// one-cycle press strobes, and tracks the run and display-freeze enables.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic clk,
    input  logic res,
    input  logic btn_start_stop,
    input  logic btn_lap,
    input  logic btn_clear,
    output logic start_stop_pulse,
    output logic lap_pulse,
    output logic clear_pulse,
    output logic counter_enable,
    output logic display_enable
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    logic [2:0] raw;
    assign raw = {btn_clear, btn_lap, btn_start_stop};
    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic s1, s2, level, level_d, pulse;
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk) begin
            if (res) begin
                s1      <= 1'b0;
                s2      <= 1'b0;
                level   <= 1'b0;
                level_d <= 1'b0;
                pulse   <= 1'b0;
                cnt     <= '0;
            end else begin
                s1      <= raw[i];
                s2      <= s1;
                level_d <= level;
                pulse   <= level & ~level_d;
                if (s2 == level)
                    cnt <= '0;
                else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level <= s2;
                    cnt   <= '0;
                end else
                    cnt <= cnt + 1'b1;
            end
        end
    end
    assign start_stop_pulse = g_ch[0].pulse;
    assign lap_pulse        = g_ch[1].pulse;
    assign clear_pulse      = g_ch[2].pulse;
    // clear wins over any coincident start/stop or lap toggle
    always_ff @(posedge clk) begin
        if (res || clear_pulse) begin
            counter_enable <= 1'b0;
            display_enable <= 1'b1;
        end else begin
            counter_enable <= counter_enable ^ start_stop_pulse;
            display_enable <= display_enable ^ lap_pulse;
        end
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios plus random button activity,
// compared every cycle against a streak-counting behavioural model.
module tb_button_conditioner;
    localparam int D = 4;
    logic clk = 1'b0;
    logic res = 1'b1;
    logic btn_start_stop = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
    logic start_stop_pulse, lap_pulse, clear_pulse, counter_enable, display_enable;
    int n_tests = 0, n_fail = 0;
    int streak [3];
    bit lvl [3], r1 [3], r2 [3], rose [3], mp [3];
    bit mce = 1'b0, mde = 1'b1;

    button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .res(res),
        .btn_start_stop(btn_start_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .start_stop_pulse(start_stop_pulse), .lap_pulse(lap_pulse), .clear_pulse(clear_pulse),
        .counter_enable(counter_enable), .display_enable(display_enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a level flips once the synchronized input (raw two edges ago) has
    // disagreed with it for D edges in a row; a strobe follows one edge after a rise.
    task automatic model_edge(input bit ss, input bit lp, input bit cl);
        bit raw [3];
        bit op [3];
        bit flip;
        raw[0] = ss; raw[1] = lp; raw[2] = cl;
        if (res) begin
            for (int c = 0; c < 3; c++) begin
                streak[c] = 0; lvl[c] = 0; r1[c] = 0; r2[c] = 0; rose[c] = 0; mp[c] = 0;
            end
            mce = 1'b0;
            mde = 1'b1;
            return;
        end
        op = mp;
        if (op[2]) begin
            mce = 1'b0;
            mde = 1'b1;
        end else begin
            mce = mce ^ op[0];
            mde = mde ^ op[1];
        end
        for (int c = 0; c < 3; c++) begin
            mp[c] = rose[c];
            flip = 1'b0;
            if (r2[c] != lvl[c]) begin
                streak[c]++;
                if (streak[c] == D) begin
                    lvl[c] = r2[c];
                    streak[c] = 0;
                    flip = 1'b1;
                end
            end else
                streak[c] = 0;
            rose[c] = flip && lvl[c];
            r2[c] = r1[c];
            r1[c] = raw[c];
        end
    endtask

    task automatic step(input bit ss, input bit lp, input bit cl);
        btn_start_stop = ss;
        btn_lap = lp;
        btn_clear = cl;
        @(posedge clk);
        model_edge(ss, lp, cl);
        #1;
        check("ss_pulse", start_stop_pulse, mp[0]);
        check("lap_pulse", lap_pulse, mp[1]);
        check("clr_pulse", clear_pulse, mp[2]);
        check("cnt_en", counter_enable, mce);
        check("disp_en", display_enable, mde);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0);
    endtask

    initial begin
        int lat;
        int hold [3];
        bit val [3];
        bit seen_all;
        res = 1'b1;
        step(0, 0, 0);
        step(1, 1, 1);
        check("rst_cnt_en", counter_enable, 0);
        check("rst_disp_en", display_enable, 1);
        res = 1'b0;
        idle(3);

        // clean start/stop press
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1, 0, 0);
            if (start_stop_pulse && lat == 0) lat = k;
        end
        check("lat_ss", lat, D + 3);
        check("ss_cnt_en_on", counter_enable, 1);
        idle(20);

        // bouncing lap press, then a second press
        step(0, 1, 0); step(0, 0, 0); step(0, 1, 0); step(0, 0, 0);
        lat = 0;
        for (int k = 1; k <= 15; k++) begin
            step(0, 1, 0);
            if (lap_pulse && lat == 0) lat = k;
        end
        check("lat_lap", lat, D + 3);
        check("lap_disp_off", display_enable, 0);
        idle(15);
        for (int k = 0; k < 12; k++) step(0, 1, 0);
        idle(15);
        check("lap_disp_on", display_enable, 1);

        // clear glitch shorter than D
        for (int k = 0; k < 3; k++) step(0, 0, 1);
        idle(15);
        check("glitch_cnt_en", counter_enable, 1);
        check("glitch_disp_en", display_enable, 1);

        // freeze display, then press all three together
        for (int k = 0; k < 12; k++) step(0, 1, 0);
        idle(15);
        check("pre_sim_disp", display_enable, 0);
        seen_all = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1, 1, 1);
            if (start_stop_pulse && lap_pulse && clear_pulse) seen_all = 1'b1;
        end
        check("sim_coincide", seen_all, 1);
        check("sim_cnt_en", counter_enable, 0);
        check("sim_disp_en", display_enable, 1);
        idle(15);

        // reset in the middle of a count
        for (int k = 0; k < 4; k++) step(1, 0, 0);
        res = 1'b1;
        step(1, 0, 0);
        res = 1'b0;
        lat = 0;
        for (int k = 1; k <= 15; k++) begin
            step(1, 0, 0);
            if (start_stop_pulse && lat == 0) lat = k;
            if (k < D + 3) check("rst_mid_cnt_en", counter_enable, 0);
        end
        check("lat_after_rst", lat, D + 3);
        idle(15);

        // random activity with occasional resets
        for (int c = 0; c < 3; c++) begin
            hold[c] = 0;
            val[c] = 1'b0;
        end
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 3; c++) begin
                if (hold[c] == 0) begin
                    val[c] = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 10);
                end
                hold[c]--;
            end
            res = ($urandom_range(0, 399) == 0);
            step(val[0], val[1], val[2]);
        end
        res = 1'b0;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
